// File: rtl/seg_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
package seg_pkg;

  // Segment vector ordered a..g, bit 0 is segment a; all values active-low.
  typedef logic [0:6] seg_t;

  typedef struct packed {
    logic [3:0] state;
    logic [2:0] energy;
    logic [2:0] hunger;
    logic [2:0] ent;
  } disp_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam seg_t       SEG_BLANK = 7'b1111111;

  localparam seg_t GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg_scan_if.sv
// Host-side bundle of the scanner: captured display data in, panel drive out.
interface seg_scan_if;
  logic       load;
  logic [3:0] state;
  logic [2:0] energy;
  logic [2:0] hunger;
  logic [2:0] entertainment;
  logic       alert;
  logic [0:6] sseg;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    output load, state, energy, hunger, entertainment, alert,
    input  sseg, an, frame_done
  );

  modport slave (
    input  load, state, energy, hunger, entertainment, alert,
    output sseg, an, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex to active-low seven-segment glyph lookup.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] val_i,
  output seg_t       seg_o
);
  assign seg_o = GLYPH[val_i];
endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed four-digit scanner with double-buffered data and alert blink on digit 0.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGIT_TICKS  = 50000,
  parameter int BLINK_FRAMES = 50
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);
  localparam int TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        idx_q, idx_d;
  logic              pflag_q, pflag_d;
  disp_t             pend_q, pend_d;
  disp_t             shadow_q, shadow_d;
  logic [BLK_W-1:0]  blk_q, blk_d;
  logic              phase_on_q, phase_on_d;
  logic              bnd_q, bnd_d;
  logic [3:0]        an_q, an_d;
  seg_t              sseg_q, sseg_d;
  logic              fd_q, fd_d;

  logic              adv;
  logic              boundary;
  disp_t             in_vals;
  logic [3:0]        digit_val;
  seg_t              glyph;

  assign in_vals  = '{state: bus.state, energy: bus.energy,
                      hunger: bus.hunger, ent: bus.entertainment};
  assign adv      = (tick_q == TICK_LAST);
  assign boundary = adv && (idx_q == 2'd3);

  always_comb begin
    digit_val = shadow_q.state;
    case (idx_q)
      2'd1:    digit_val = {1'b0, shadow_q.energy};
      2'd2:    digit_val = {1'b0, shadow_q.hunger};
      2'd3:    digit_val = {1'b0, shadow_q.ent};
      default: digit_val = shadow_q.state;
    endcase
  end

  seg7_decode u_dec (
    .val_i (digit_val),
    .seg_o (glyph)
  );

  always_comb begin
    tick_d     = adv ? '0 : tick_q + 1'b1;
    idx_d      = adv ? idx_q + 2'd1 : idx_q;
    pend_d     = pend_q;
    pflag_d    = pflag_q;
    shadow_d   = shadow_q;
    blk_d      = blk_q;
    phase_on_d = phase_on_q;

    if (bus.load) begin
      pend_d  = in_vals;
      pflag_d = 1'b1;
    end
    // A load landing on the boundary bypasses pending so it is not a frame late.
    if (boundary) begin
      if (bus.load) begin
        shadow_d = in_vals;
        pflag_d  = 1'b0;
      end else if (pflag_q) begin
        shadow_d = pend_q;
        pflag_d  = 1'b0;
      end
    end

    if (!bus.alert) begin
      blk_d      = '0;
      phase_on_d = 1'b1;
    end else if (boundary) begin
      if (blk_q == BLK_LAST) begin
        blk_d      = '0;
        phase_on_d = !phase_on_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end

    // frame_done is delayed one extra cycle so it lines up with digit 0 on the outputs.
    bnd_d  = boundary;
    fd_d   = bnd_q;
    an_d   = ~(4'b0001 << idx_q);
    sseg_d = ((idx_q == 2'd0) && bus.alert && !phase_on_q) ? SEG_BLANK : glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= '0;
      idx_q      <= 2'd0;
      pflag_q    <= 1'b0;
      pend_q     <= '0;
      shadow_q   <= '0;
      blk_q      <= '0;
      phase_on_q <= 1'b1;
      bnd_q      <= 1'b0;
      an_q       <= ANODE_OFF;
      sseg_q     <= SEG_BLANK;
      fd_q       <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      pflag_q    <= pflag_d;
      pend_q     <= pend_d;
      shadow_q   <= shadow_d;
      blk_q      <= blk_d;
      phase_on_q <= phase_on_d;
      bnd_q      <= bnd_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGIT_TICKS, default 50000, clk cycles each digit is driven (min 2).
REQ-002 Parameter BLINK_FRAMES, default 50, frames per blink half-period (min 1).
REQ-003 clk  in  1  system clock; one clock domain, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load  in  1  one-cycle strobe; capture state/energy/hunger/entertainment.
REQ-006 state  in  4  FSM state code, shown as hex on digit 0.
REQ-007 energy  in  3  stat 0-7, digit 1.
REQ-008 hunger  in  3  stat 0-7, digit 2.
REQ-009 entertainment  in  3  stat 0-7, digit 3.
REQ-010 alert  in  1  level; while high digit 0 blinks.
REQ-011 sseg  out  [0:6]  segments a..g, active-low, registered.
REQ-012 an  out  4  anodes, active-low, one-hot-low, registered; an[i] selects digit i.
REQ-013 frame_done  out  1  one-cycle pulse at each 3->0 digit wrap.

Function
REQ-014 tick counter SHALL count 0..DIGIT_TICKS-1 and wrap; wrap cycle is the digit-advance event.
REQ-015 Digit index SHALL advance 0->1->2->3->0 on each advance event; no other states.
REQ-016 Data SHALL pass through pending registers and then shadow registers; display uses shadow only.
REQ-017 load=1 SHALL overwrite pending with inputs and set the pending flag; a later load before commit overwrites, and the last one wins.
REQ-018 At frame boundary (advance event with index 3) with pending flag set, shadow SHALL take pending and the flag SHALL clear.
REQ-019 load coinciding with a frame boundary SHALL commit the newly loaded inputs directly to shadow in that cycle.
REQ-020 frame_done SHALL assert for exactly the cycle after the boundary event, aligned with the first cycle of digit 0 on an.
REQ-021 sseg/an SHALL reflect the current index and shadow with one cycle of register latency.
REQ-022 Stats SHALL be zero-extended to 4 bits; hex decode 0-F uses standard glyphs (b, d lowercase).
REQ-023 Blink phase SHALL toggle every BLINK_FRAMES frame boundaries.
REQ-024 While alert=1 and blink phase=off, digit 0 SHALL be blanked (sseg=7'b1111111, an still 4'b1110); digits 1-3 are unaffected.
REQ-025 When alert falls, the blink phase counter SHALL reset to phase=on, count 0, at once.
REQ-026 State/stat inputs SHALL have no effect without load.

Reset
REQ-027 On rst=1 the following SHALL be set: tick=0, index=0, pending flag=0, pending=0, shadow=0, blink count=0, phase=on.
REQ-028 Outputs SHALL be set to an=4'b1111, sseg=7'b1111111, frame_done=0 in the cycle after rst is sampled high.
REQ-029 The first cycle after rst falls SHALL drive digit 0 with value 0 (an=4'b1110, sseg=7'b0000001).
REQ-030 rst mid-frame SHALL abort the scan and discard pending data.

Structure
REQ-031 Shared package seg_pkg SHALL hold ANODE_OFF=4'b1111, SEG_BLANK=7'b1111111 and the 16-entry glyph table.
REQ-032 One sub-module SHALL exist: seg7_decode (combinational, 4-bit value in, [0:6] active-low out); the rest is flat in seg_scan.

Verification (DIGIT_TICKS=4, BLINK_FRAMES=2)
REQ-033 Test: reset, then run 16 cycles. Required response: an sequence 1110,1101,1011,0111, each held 4 cycles; sseg=0000001 on all digits; frame_done high 1 cycle at cycle 16.
REQ-034 Test: load state=4'hA, energy=5 mid-frame. Required response: display unchanged until the next frame_done; then digit 0 shows 0001000 and digit 1 shows 0100100.
REQ-035 Test: load 3 then load 7 within one frame. Required response: only 7 ever appears.
REQ-036 Test: load asserted exactly on the boundary cycle. Required response: new values appear in the very next digit-0 slot.
REQ-037 Test: alert=1 for 8 frames. Required response: digit 0 shown for 2 frames, blank for 2 frames, repeating; digits 1-3 always lit; alert=0 restores digit 0 immediately.
REQ-038 Test: rst mid-frame with a pending load. Required response: outputs blank for 1 cycle, then digit 0 shows 0; the pending value is never displayed.
